// File: rtl/polarity_restore_rx_if.sv
// Serial handshake bundle between the bit-sampling front end, polarity_restore_rx and downstream framing.
interface polarity_restore_rx_if;
  logic din;
  logic din_valid;
  logic relock;
  logic dout;
  logic dout_valid;
  logic locked;
  logic inverted;
  logic sync_hit;
  logic frame_end;

  modport master (
    output din, din_valid, relock,
    input  dout, dout_valid, locked, inverted, sync_hit, frame_end
  );

  modport slave (
    input  din, din_valid, relock,
    output dout, dout_valid, locked, inverted, sync_hit, frame_end
  );
endinterface

// File: rtl/polarity_restore_rx.sv
// Hunts for SYNC_WORD in true or complemented form, latches polarity, then emits FRAME_LEN corrected bits.
// Optional idle timeout while LOCKED is enabled by defining POL_TIMEOUT_EN.
module polarity_restore_rx #(
  parameter int unsigned       SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hD5,
  parameter int unsigned       FRAME_LEN = 16,
  parameter int unsigned       CNT_W     = 5,
  parameter int unsigned       TIMEOUT   = 64
) (
  input logic                 clk,
  input logic                 rst_n,
  polarity_restore_rx_if.slave bus
);

  localparam int unsigned FILL_W = $clog2(SYNC_W + 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [SYNC_W-1:0] sr_q, sr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  pay_q, pay_d;
  logic              dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              locked_q, locked_d;
  logic              inverted_q, inverted_d;
  logic              sync_hit_q, sync_hit_d;
  logic              frame_end_q, frame_end_d;

  logic [SYNC_W-1:0] nxt;
  logic              can_match;
  logic              drop;

`ifdef POL_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    fill_d       = fill_q;
    pay_d        = pay_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sync_hit_d   = 1'b0;
    frame_end_d  = 1'b0;
    inverted_d   = inverted_q;
    drop         = 1'b0;
`ifdef POL_TIMEOUT_EN
    idle_d       = '0;
`endif
    nxt       = {sr_q[SYNC_W-2:0], bus.din};
    // The current bit counts toward the fill, so one short of SYNC_W already qualifies.
    can_match = (fill_q >= FILL_W'(SYNC_W - 1));

    case (state_q)
      HUNT: begin
        if (bus.relock) begin
          fill_d = '0;
        end else if (bus.din_valid) begin
          sr_d = nxt;
          if (fill_q != FILL_W'(SYNC_W)) fill_d = fill_q + FILL_W'(1);
          if (can_match && (nxt == SYNC_WORD || nxt == ~SYNC_WORD)) begin
            state_d    = LOCKED;
            sync_hit_d = 1'b1;
            inverted_d = (nxt != SYNC_WORD);
            pay_d      = '0;
          end
        end
      end
      LOCKED: begin
        if (bus.relock) begin
          drop = 1'b1;
        end else if (bus.din_valid) begin
          dout_d       = bus.din ^ inverted_q;
          dout_valid_d = 1'b1;
          if (pay_q == CNT_W'(FRAME_LEN - 1)) begin
            frame_end_d = 1'b1;
            drop        = 1'b1;
          end else begin
            pay_d = pay_q + CNT_W'(1);
          end
        end
`ifdef POL_TIMEOUT_EN
        else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
          drop = 1'b1;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
`endif
      end
      default: drop = 1'b1;
    endcase

    if (drop) begin
      state_d = HUNT;
      sr_d    = '0;
      fill_d  = '0;
      pay_d   = '0;
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      sr_q         <= '0;
      fill_q       <= '0;
      pay_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      inverted_q   <= 1'b0;
      sync_hit_q   <= 1'b0;
      frame_end_q  <= 1'b0;
`ifdef POL_TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      fill_q       <= fill_d;
      pay_q        <= pay_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      locked_q     <= locked_d;
      inverted_q   <= inverted_d;
      sync_hit_q   <= sync_hit_d;
      frame_end_q  <= frame_end_d;
`ifdef POL_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.locked     = locked_q;
  assign bus.inverted   = inverted_q;
  assign bus.sync_hit   = sync_hit_q;
  assign bus.frame_end  = frame_end_q;

endmodule
